// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, mid-bit sampling after a 2-flop synchronizer.
// state     | meaning
// IDLE      | line idle, waiting for rx_s low
// START     | counting to mid start bit, rejects glitches
// DATA      | sampling 8 data bits LSB first
// STOP      | sampling stop bit, emits valid or frame_err
// WAIT_HIGH | after a framing error, waits for the line to return high
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_idx, bit_idx_nx;
  logic [7:0]       shift_reg, shift_nx;
  logic [7:0]       data_nx;
  logic             valid_nx, frame_err_nx;
  logic             rx_meta, rx_s;

  // Idle-high reset value keeps the synchronizer from faking a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bit_idx   <= bit_idx_nx;
      shift_reg <= shift_nx;
      data_out  <= data_nx;
      valid     <= valid_nx;
      frame_err <= frame_err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt + CNT_W'(1);
    bit_idx_nx   = bit_idx;
    shift_nx     = shift_reg;
    data_nx      = data_out;
    valid_nx     = 1'b0;
    frame_err_nx = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (!rx_s) begin
          state_nx   = START;
          bit_idx_nx = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nx   = '0;
          state_nx = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nx            = '0;
          shift_nx[bit_idx] = rx_s;
          if (bit_idx == 3'd7) state_nx = STOP;
          else bit_idx_nx = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nx = '0;
          if (rx_s) begin
            data_nx  = shift_reg;
            valid_nx = 1'b1;
            state_nx = IDLE;
          end else begin
            frame_err_nx = 1'b1;
            state_nx     = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_nx = '0;
        if (rx_s) state_nx = IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: time-based frame model checked every cycle, plus literal checks.
module tb_uart_rx;
  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       valid, frame_err, busy;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data_out(data_out),
    .valid(valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Model: frame timing from absolute cycle offsets relative to the detected start.
  logic       m_s1 = 1'b1, m_s2 = 1'b1, m_r;
  int         m_mode = 0;
  int         m_t0 = 0;
  int         m_off, m_k;
  logic [7:0] m_bits = 8'h00;
  logic [7:0] exp_data = 8'h00;
  logic       exp_valid = 1'b0, exp_ferr = 1'b0, exp_busy = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    m_r = m_s2;
    exp_valid = 1'b0;
    exp_ferr  = 1'b0;
    if (rst) begin
      m_mode = 0;
      m_s1 = 1'b1;
      m_s2 = 1'b1;
      m_bits = 8'h00;
      exp_data = 8'h00;
    end else begin
      case (m_mode)
        0: if (!m_r) begin
          m_mode = 1;
          m_t0 = cyc;
        end
        1: begin
          m_off = cyc - m_t0;
          if (m_off == N / 2) begin
            if (m_r) m_mode = 0;
          end else if (m_off > N / 2 && (m_off - N / 2) % N == 0) begin
            m_k = (m_off - N / 2) / N;
            if (m_k <= 8) m_bits[m_k-1] = m_r;
            else if (m_r) begin
              exp_data = m_bits;
              exp_valid = 1'b1;
              m_mode = 0;
            end else begin
              exp_ferr = 1'b1;
              m_mode = 2;
            end
          end
        end
        default: if (m_r) m_mode = 0;
      endcase
      m_s2 = m_s1;
      m_s1 = rx;
    end
    exp_busy = (m_mode != 0);
  end

  always @(posedge clk) begin
    #1;
    chk("valid", 32'(valid), 32'(exp_valid));
    chk("frame_err", 32'(frame_err), 32'(exp_ferr));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("data_out", 32'(data_out), 32'(exp_data));
  end

  int         v_cyc[$];
  logic [7:0] v_dat[$];
  int         ferr_n = 0;

  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) begin
      v_cyc.push_back(cyc);
      v_dat.push_back(data_out);
    end
    if (frame_err === 1'b1) ferr_n++;
  end

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = v;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop, output int start_cyc);
    @(negedge clk);
    rx = 1'b0;
    start_cyc = cyc;
    drive(1'b0, N - 1);
    for (int i = 0; i < 8; i++) drive(b[i], N);
    drive(stop, N);
  endtask

  // Disturb each bit away from its centre; stop bit left clean.
  task automatic send_noisy(input logic [7:0] b);
    logic [8:0] bits;
    bits = {b, 1'b0};
    for (int i = 0; i < 9; i++) begin
      for (int o = 0; o < N; o++) begin
        @(negedge clk);
        rx = (o == 2 || o == 3 || o == 12 || o == 13) ? ~bits[i] : bits[i];
      end
    end
    drive(1'b1, N);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_data_out"}, 32'(data_out), 32'h00);
  endtask

  initial begin
    int s0, s1, base, fbase;
    logic [7:0] b55;
    b55 = 8'h55;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst_init");
    rst = 1'b0;
    drive(1'b1, 3);

    // Good frame 0xA5: valid 155 cycles after the start bit is driven (2 sync + 153).
    base = v_cyc.size();
    send(8'hA5, 1'b1, s0);
    drive(1'b1, 4);
    chk("a5_count", 32'(v_cyc.size() - base), 32'd1);
    if (v_cyc.size() > base) begin
      chk("a5_latency", 32'(v_cyc[base] - s0), 32'd155);
      chk("a5_data", 32'(v_dat[base]), 32'hA5);
    end
    chk("a5_no_ferr", 32'(ferr_n), 32'd0);

    // Glitch: 4 low cycles, FSM back in IDLE 9 cycles after rx_s falls.
    base = v_cyc.size();
    drive(1'b0, 4);
    drive(1'b1, 7);
    chk("glitch_busy_hi", 32'(busy), 32'd1);
    drive(1'b1, 1);
    chk("glitch_busy_lo", 32'(busy), 32'd0);
    drive(1'b1, 10);
    chk("glitch_no_valid", 32'(v_cyc.size() - base), 32'd0);
    chk("glitch_no_ferr", 32'(ferr_n), 32'd0);

    // Framing error on 0x3C, then a held break.
    base = v_cyc.size();
    send(8'h3C, 1'b0, s0);
    drive(1'b0, 40);
    chk("ferr_count", 32'(ferr_n), 32'd1);
    chk("ferr_busy_held", 32'(busy), 32'd1);
    chk("ferr_data_kept", 32'(data_out), 32'hA5);
    chk("ferr_no_valid", 32'(v_cyc.size() - base), 32'd0);
    drive(1'b1, 5);
    chk("ferr_busy_released", 32'(busy), 32'd0);

    // Back-to-back 0x00 then 0xFF.
    base = v_cyc.size();
    send(8'h00, 1'b1, s0);
    send(8'hFF, 1'b1, s1);
    drive(1'b1, 4);
    chk("b2b_count", 32'(v_cyc.size() - base), 32'd2);
    if (v_cyc.size() >= base + 2) begin
      chk("b2b_spacing", 32'(v_cyc[base+1] - v_cyc[base]), 32'd160);
      chk("b2b_data0", 32'(v_dat[base]), 32'h00);
      chk("b2b_data1", 32'(v_dat[base+1]), 32'hFF);
    end

    // 0xA5 with disturbances between sample points.
    base = v_cyc.size();
    send_noisy(8'hA5);
    drive(1'b1, 4);
    chk("noisy_count", 32'(v_cyc.size() - base), 32'd1);
    if (v_cyc.size() > base) chk("noisy_data", 32'(v_dat[base]), 32'hA5);

    // Reset in the middle of bit 4 of 0x55, then 0x81.
    base = v_cyc.size();
    fbase = ferr_n;
    drive(1'b0, N);
    for (int i = 0; i < 4; i++) drive(b55[i], N);
    drive(b55[4], N / 2);
    chk("mid_busy_before_rst", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    repeat (4) @(negedge clk);
    chk_reset_outputs("rst_hold");
    rst = 1'b0;
    drive(1'b1, 3);
    send(8'h81, 1'b1, s0);
    drive(1'b1, 4);
    chk("rst_count", 32'(v_cyc.size() - base), 32'd1);
    if (v_cyc.size() > base) begin
      chk("rst_data", 32'(v_dat[base]), 32'h81);
      chk("rst_latency", 32'(v_cyc[base] - s0), 32'd155);
    end
    chk("rst_no_ferr", 32'(ferr_n - fbase), 32'd0);

    drive(1'b1, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk, rst.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit period N; even values only, N >= 4.
REQ-003 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 Port rx, input, 1 bit: serial line, asynchronous to clk, idle high.
REQ-006 Port data_out, output, 8 bits: last correctly framed byte received.
REQ-007 Port valid, output, 1 bit: single-cycle pulse when data_out is updated.
REQ-008 Port frame_err, output, 1 bit: single-cycle pulse when the stop bit is sampled low.
REQ-009 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (rx_s); the FSM SHALL use only rx_s.
REQ-011 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-012 The FSM SHALL have exactly these states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE: at cycle t0, when rx_s==0, the FSM SHALL go to START and clear the cycle counter and bit index.
REQ-014 START: the FSM SHALL sample rx_s at t0+N/2; if 0, go to DATA; if 1 (glitch), return to IDLE with no output pulse.
REQ-015 DATA: data bit k (k=0..7) SHALL be sampled at t0+N/2+(k+1)*N into bit k of a shift register; after k=7 the FSM SHALL go to STOP.
REQ-016 STOP: the stop bit SHALL be sampled at t0+N/2+9*N.
REQ-017 On a stop sample of 1: data_out SHALL load the shift register and valid SHALL be high for exactly the next cycle, with the FSM going to IDLE.
REQ-018 On a stop sample of 0: frame_err SHALL be high for exactly the next cycle, data_out SHALL be unchanged, valid SHALL stay 0, and the FSM SHALL go to WAIT_HIGH.
REQ-019 WAIT_HIGH: the FSM SHALL stay until rx_s==1, then go to IDLE; a break condition therefore never restarts reception.
REQ-020 Back-to-back frames (next start bit immediately after the stop bit) SHALL be received without loss; IDLE SHALL detect the new start on the first rx_s==0 cycle after returning.
REQ-021 valid and frame_err SHALL never be high in the same cycle.
REQ-022 data_out SHALL be stable between valid pulses.
REQ-023 The cycle counter SHALL be ceil(log2(N)) bits wide and SHALL be reset at each sample point; it SHALL never wrap uncontrolled.
REQ-024 Latency from the rx_s falling edge (t0) to valid SHALL be N/2+9*N+1 cycles.
REQ-025 rx changes while busy outside sample points SHALL have no effect.

Reset
REQ-026 While rst is high: state=IDLE, synchronizer flops=1, counters=0, shift register=0, data_out=0x00, valid=0, frame_err=0, busy=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately with no valid or frame_err pulse.
REQ-028 After reset release, the first frame whose start bit begins at least 2 cycles later SHALL be received correctly.

Verification (N=16)
REQ-029 Send 0xA5 with a good stop bit -> one valid pulse at t0+153, data_out=0xA5, frame_err=0 throughout.
REQ-030 Drive rx low for 4 cycles then high -> FSM returns to IDLE, no valid, no frame_err, busy low again by t0+9.
REQ-031 Send 0x3C with stop bit 0, hold rx low 40 more cycles -> one frame_err pulse, data_out keeps its prior value, busy stays high until rx_s returns to 1.
REQ-032 Send 0x00 then 0xFF back-to-back -> two valid pulses 160 cycles apart, data_out 0x00 then 0xFF.
REQ-033 Assert rst during bit 4 of 0x55, release, then send 0x81 -> all outputs 0 during reset, no pulse for 0x55, valid with data_out=0x81.
REQ-034 Send 0xA5 with rx toggled between sample points (except mid-bit) -> data_out=0xA5.
